// File: rtl/dcache_pkg.sv
// Purpose : shared types and sizing helpers for the direct-mapped data cache.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package dcache_pkg;

    // Default number of one-word lines.
    localparam int DEF_LINES = 64;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    // Registered request. The address is stored word-aligned.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } req_t;

    // Index width: log2 of the line count.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: word address bits left over after the index.
    function automatic int tag_w(input int lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Purpose : data/tag/valid storage for the cache. It has one byte-masked write port,
//           one async read port for the held request and one async tag lookup port for the incoming address.
// Latency : reads are combinational, and writes take effect at the rising edge.
// Backpressure : none. A write is taken on every cycle that i_wr_en is high.
// Ports   : clk/rst, rd (req_q line: data+tag+valid), lk (incoming line: tag+valid),
//           wr (idx, byte mask, data, tag; always sets valid).
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int IDX_W = idx_w(LINES),
    parameter int TAG_W = tag_w(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic             o_rd_vld,
    input  logic [IDX_W-1:0] i_lk_idx,
    output logic [TAG_W-1:0] o_lk_tag,
    output logic             o_lk_vld,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [3:0]       i_wr_mask,
    input  logic [31:0]      i_wr_data,
    input  logic [TAG_W-1:0] i_wr_tag
);

    logic [LINES-1:0]  r_vld;
    logic [3:0][7:0]   r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];

    // Only the valid bits need reset. Data and tag are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (i_wr_en) begin
            r_vld[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[i_wr_idx][b] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_data = r_data[i_rd_idx];
    assign o_rd_tag  = r_tag[i_rd_idx];
    assign o_rd_vld  = r_vld[i_rd_idx];
    assign o_lk_tag  = r_tag[i_lk_idx];
    assign o_lk_vld  = r_vld[i_lk_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Purpose : direct-mapped write-through, no-write-allocate data cache controller with one-word lines.
// Latency : a read hit returns data 1 cycle after acceptance. A miss or a write stalls until the memory handshake completes.
// Backpressure : stall freezes the pipeline. The mem_req_* outputs hold steady until mem_req_ready.
// Ports   : pipeline side dcache_addr/we/re/din -> dcache_dout, stall;
//           memory side mem_req_{valid,ready,rnw,addr,data,mask}, mem_resp_{valid,data}.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = DEF_LINES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic [3:0]  dcache_we,
    input  logic        dcache_re,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rnw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t      r_state;
    state_t      w_state_nxt;
    req_t        r_req;
    logic        r_rd_pend;     // accepted read not yet returned to the pipeline
    logic [31:0] r_dout;

    logic [IDX_W-1:0] w_req_idx, w_in_idx, w_wr_idx;
    logic [TAG_W-1:0] w_req_tag, w_in_tag, w_wr_tag;
    logic [TAG_W-1:0] w_rd_tag, w_lk_tag;
    logic [31:0]      w_rd_data, w_wr_data, w_dout;
    logic [3:0]       w_wr_mask;
    logic             w_rd_vld, w_lk_vld, w_hit, w_is_wr, w_accept;
    logic             w_fill, w_wr_hit, w_wr_en;
    logic             w_unused;

    // The byte offset is ignored. Lane selection happens outside this block.
    assign w_unused  = &{1'b0, dcache_addr[1:0]};

    assign w_req_idx = r_req.addr[IDX_W+1:2];
    assign w_req_tag = r_req.addr[31:IDX_W+2];
    assign w_in_idx  = dcache_addr[IDX_W+1:2];
    assign w_in_tag  = dcache_addr[31:IDX_W+2];
    assign w_is_wr   = |dcache_we;

    // Hit for the held request and hit for the incoming store.
    assign w_hit     = w_rd_vld && (w_rd_tag == w_req_tag);
    assign w_accept  = !stall && (w_is_wr || dcache_re);
    assign w_wr_hit  = w_accept && w_is_wr && w_lk_vld && (w_lk_tag == w_in_tag);

    // A response is only honoured in RD_WAIT, which also drops a response that
    // arrives together with ready in RD_REQ.
    assign w_fill    = (r_state == ST_RD_WAIT) && mem_resp_valid;
    assign w_wr_en   = w_fill || w_wr_hit;
    assign w_wr_idx  = w_fill ? w_req_idx     : w_in_idx;
    assign w_wr_tag  = w_fill ? w_req_tag     : w_in_tag;
    assign w_wr_mask = w_fill ? 4'hF          : dcache_we;
    assign w_wr_data = w_fill ? mem_resp_data : dcache_din;

    dcache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (reset),
        .i_rd_idx  (w_req_idx),
        .o_rd_data (w_rd_data),
        .o_rd_tag  (w_rd_tag),
        .o_rd_vld  (w_rd_vld),
        .i_lk_idx  (w_in_idx),
        .o_lk_tag  (w_lk_tag),
        .o_lk_vld  (w_lk_vld),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_mask (w_wr_mask),
        .i_wr_data (w_wr_data),
        .i_wr_tag  (w_wr_tag)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // Acceptance needs stall=0, which excludes a pending miss.
                if (w_accept && w_is_wr) begin
                    w_state_nxt = ST_WRITE;
                end else if (r_rd_pend && !w_hit) begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_WRITE:   if (mem_req_ready)  w_state_nxt = ST_IDLE;
            ST_RD_REQ:  if (mem_req_ready)  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (mem_resp_valid) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. Every field comes from state and req_q, so it stays stable while a request waits.
    always_comb begin
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rnw   = 1'b0;
        mem_req_addr  = r_req.addr;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        case (r_state)
            ST_IDLE: begin
                stall = r_rd_pend && !w_hit;
            end
            ST_WRITE: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_data  = r_req.din;
                mem_req_mask  = r_req.we;
            end
            ST_RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_rnw   = 1'b1;
            end
            ST_RD_WAIT: begin
                stall = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // The load word is live only when a pending read hits. Otherwise the last value is held.
    assign w_dout      = (r_state == ST_IDLE && r_rd_pend && w_hit) ? w_rd_data : r_dout;
    assign dcache_dout = w_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req     <= '0;
            r_rd_pend <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_dout <= w_dout;
            if (w_accept) begin
                r_req.addr <= {dcache_addr[31:2], 2'b00};
                r_req.we   <= dcache_we;
                r_req.din  <= dcache_din;
                r_rd_pend  <= !w_is_wr;
            end else if (!stall) begin
                r_rd_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Purpose : randomized self-checking bench for dcache_ctrl against a cache/memory reference model.
// Latency : n/a.
// Backpressure : the bench plays the memory and uses chosen ready and response delays.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rnw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_we      (dcache_we),
        .dcache_re      (dcache_re),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: backing memory, the cache's tag/valid view, and the last load word.
    logic [31:0] ref_mem [bit [29:0]];
    bit          c_vld [64];
    logic [23:0] c_tag [64];
    logic [31:0] m_dout;

    function automatic logic [31:0] mem_word(input bit [29:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return {wa[15:0], ~wa[15:0]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) c_vld[i] = 1'b0;
        m_dout = 32'h0;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        dcache_addr    = '0;
        dcache_we      = '0;
        dcache_re      = 1'b0;
        dcache_din     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Idle cycles with no request, plus stray responses that must be ignored.
    task automatic idle(input int n);
        dcache_we = '0;
        dcache_re = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_resp_valid = ($urandom_range(0, 1) == 0);
            mem_resp_data  = $urandom;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            chk("idle_stall", 32'(stall), 32'h0);
            chk("idle_valid", 32'(mem_req_valid), 32'h0);
        end
    endtask

    // Issue one request from a negedge with stall=0. The bench also acts as memory,
    // giving ready after rdy_dly valid cycles and the read response rsp_dly cycles into the wait.
    task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                          input int rdy_dly, input int rsp_dly,
                          output int n_stall, output int n_req);
        logic [29:0] wa;
        int          idx;
        logic [23:0] tg;
        bit          is_wr, hit, done, rsp_pend;
        logic [31:0] exp_w, nw;
        int          exp_stall, exp_req, vcnt, wcnt;
        wa        = a[31:2];
        idx       = int'(a[7:2]);
        tg        = a[31:8];
        is_wr     = (we != 4'b0);
        hit       = c_vld[idx] && (c_tag[idx] == tg);
        exp_w     = mem_word(wa);
        exp_stall = is_wr ? rdy_dly + 1 : (hit ? 0 : 3 + rdy_dly + rsp_dly);
        exp_req   = (is_wr || !hit) ? 1 : 0;

        dcache_addr = a;
        dcache_we   = we;
        dcache_din  = d;
        dcache_re   = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n_stall = 0; n_req = 0; vcnt = 0; wcnt = 0; done = 0; rsp_pend = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (!stall) begin
                done = 1;
            end else begin
                n_stall++;
                chk("hold_dout", dcache_dout, m_dout);
                if (mem_req_valid) begin
                    chk("req_rnw", 32'(mem_req_rnw), 32'(!is_wr));
                    chk("req_addr", mem_req_addr, {a[31:2], 2'b00});
                    if (is_wr) begin
                        chk("req_data", mem_req_data, d);
                        chk("req_mask", 32'(mem_req_mask), 32'(we));
                    end
                    // A stray response outside RD_WAIT, including one that arrives with ready.
                    mem_resp_valid = ($urandom_range(0, 3) == 0);
                    if (vcnt == rdy_dly) begin
                        mem_req_ready = 1'b1;
                        n_req++;
                        rsp_pend = !is_wr;
                        wcnt = 0;
                    end
                    vcnt++;
                end else if (rsp_pend) begin
                    if (wcnt == rsp_dly) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = exp_w;
                        rsp_pend = 0;
                    end
                    wcnt++;
                end
            end
        end
        chk("done", 32'(done), 32'h1);
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
        chk("mem_reqs", 32'(n_req), 32'(exp_req));
        chk("end_valid", 32'(mem_req_valid), 32'h0);
        if (is_wr) begin
            chk("dout_kept", dcache_dout, m_dout);
            nw = exp_w;
            for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = d[8*b +: 8];
            ref_mem[wa] = nw;
        end else begin
            chk("load", dcache_dout, exp_w);
            m_dout = exp_w;
            if (!hit) begin
                c_vld[idx] = 1'b1;
                c_tag[idx] = tg;
            end
        end
    endtask

    int  ns, nr;
    bit  seen;
    logic [31:0] ra;

    initial begin
        apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_rnw", 32'(mem_req_rnw), 32'h0);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_data", mem_req_data, 32'h0);
        chk("rst_mask", 32'(mem_req_mask), 32'h0);
        chk("rst_dout", dcache_dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, ready at once, response two cycles after ready.
        ref_mem[30'h10] = 32'h1234_5678;
        do_req(32'h40, 4'b0000, 32'h0, 0, 1, ns, nr);
        chk("cold_stall4", 32'(ns), 32'd4);
        chk("cold_dout", dcache_dout, 32'h1234_5678);
        // Re-read hits with no memory traffic.
        do_req(32'h40, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("hit_stall0", 32'(ns), 32'd0);
        chk("hit_nreq0", 32'(nr), 32'd0);
        // Byte store on the hit line, with ready held low for three cycles.
        do_req(32'h41, 4'b0010, 32'h0000_AB00, 3, 0, ns, nr);
        chk("st_stall", 32'(ns), 32'd4);
        do_req(32'h40, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("st_merged", dcache_dout, 32'h1234_AB78);
        chk("st_rd_hit", 32'(ns), 32'd0);
        // A store to an uncached line does not allocate.
        do_req(32'h100, 4'b1111, 32'hCAFE_F00D, 1, 0, ns, nr);
        chk("nowa_wr_req", 32'(nr), 32'd1);
        do_req(32'h100, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("nowa_rd_miss", 32'(nr), 32'd1);
        chk("nowa_rd_data", dcache_dout, 32'hCAFE_F00D);
        // Two addresses that map to the same line.
        do_req(32'h004, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("alias_a_miss", 32'(nr), 32'd1);
        do_req(32'h104, 4'b0000, 32'h0, 1, 2, ns, nr);
        chk("alias_b_miss", 32'(nr), 32'd1);
        do_req(32'h004, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("alias_evict", 32'(nr), 32'd1);

        // Reset in RD_WAIT, followed by a late response.
        dcache_addr = 32'h200; dcache_we = '0; dcache_re = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                seen = 1;
            end
        end
        chk("rw_req_seen", 32'(seen), 32'h1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_in_wait", 32'(stall), 32'h1);
        reset = 1'b1; dcache_re = 1'b0; dcache_addr = '0;
        model_reset();
        #1;
        chk("rw_rst_stall", 32'(stall), 32'h0);
        chk("rw_rst_dout", dcache_dout, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rw_late_stall", 32'(stall), 32'h0);
        chk("rw_late_valid", 32'(mem_req_valid), 32'h0);
        chk("rw_late_dout", dcache_dout, 32'h0);
        do_req(32'h200, 4'b0000, 32'h0, 0, 0, ns, nr);
        chk("rw_refetch", 32'(nr), 32'd1);

        // Random traffic over a small footprint so that hits, aliases and write hits all occur.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 2));
            ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 6)
                do_req(ra, 4'b0000, 32'h0, $urandom_range(0, 3), $urandom_range(0, 3), ns, nr);
            else
                do_req(ra, 4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3), 0, ns, nr);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001: LINES, default 64, number of direct-mapped one-word lines; power of two, 4..256.
REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: dcache_addr  input  32  byte address from the Stage 3 datapath; bits [1:0] ignored.
REQ-005: dcache_we  input  4  per-byte write enables; nonzero means store.
REQ-006: dcache_re  input  1  read enable (tied high by the pipeline).
REQ-007: dcache_din  input  32  store data, already lane-aligned.
REQ-008: dcache_dout  output  32  full load word, unshifted; byte selection is downstream.
REQ-009: stall  output  1  high = pipeline must freeze and hold all dcache_* inputs.
REQ-010: mem_req_valid  output  1  backing-memory request valid.
REQ-011: mem_req_ready  input  1  backing memory accepts the request.
REQ-012: mem_req_rnw  output  1  1 = read, 0 = write.
REQ-013: mem_req_addr  output  32  word-aligned address, with bits [1:0] = 0.
REQ-014: mem_req_data  output  32  write data; mem_req_mask  output  4  write byte mask.
REQ-015: mem_resp_valid  input  1  read data valid; mem_resp_data  input  32  read data.

Function
REQ-016: Address split: index = addr[IDX+1:2] with IDX = log2(LINES); tag = addr[31:IDX+2].
REQ-017: Accept a request on a rising edge where stall=0 and (dcache_we!=0 or dcache_re=1), and register it in req_q.
REQ-018: If dcache_we!=0, treat the request as a write, ignoring dcache_re.
REQ-019: FSM states: IDLE, WRITE, RD_REQ, RD_WAIT.
REQ-020: Read hit: in the cycle after acceptance, state IDLE, dcache_dout = line data and stall=0, giving 1-cycle latency.
REQ-021: Read miss in the cycle after acceptance:
  - stall=1 combinationally from the tag/valid compare;
  - go to RD_REQ on the next edge.
REQ-022: RD_REQ:
  - drive mem_req_valid=1, rnw=1, addr={req_q addr[31:2],2'b00};
  - on mem_req_ready go to RD_WAIT.
REQ-023: RD_WAIT:
  - on mem_resp_valid, write data, tag and valid=1 into the line and return to IDLE;
  - the held read then hits, so dout is valid and stall=0 in the following cycle.
REQ-024: Write acceptance on a hit: update the enabled bytes of the line at the accepting edge.
REQ-025: Write acceptance on a miss: leave the array unchanged (write-through, no-allocate).
REQ-026: Every write enters WRITE:
  - drive mem_req_valid=1, rnw=0, data=din and mask=we;
  - stall=1;
  - on mem_req_ready return to IDLE, with stall=0 in the next cycle.
REQ-027: Hold stall=1 in WRITE, RD_REQ and RD_WAIT.
REQ-028: Hold all mem_req_* outputs stable while mem_req_valid=1 and mem_req_ready=0.
REQ-029: Ignore mem_resp_valid outside RD_WAIT.
REQ-030: mem_req_ready and mem_resp_valid in the same RD_REQ cycle: treat as ready only, and do not fill.
REQ-031: Read of a line written in the immediately preceding request: return the updated bytes.
REQ-032: dcache_dout holds its last value while stall=1 and when no read is pending.

Reset
REQ-033: On reset assertion:
  - all valid bits clear, state=IDLE and req_q cleared;
  - stall=0, mem_req_valid=0, mem_req_rnw=0, mem_req_addr=0, mem_req_data=0, mem_req_mask=0 and dcache_dout=0.
REQ-034: Reset during RD_REQ, RD_WAIT or WRITE abandons the transaction and leaves no partial fill; a late mem_resp_valid is ignored.

Structure
REQ-035: Package dcache_pkg holds the FSM state enum, the default LINES and the tag/index width helpers.
REQ-036: Storage sits in one sub-module, dcache_line_array, containing data, tag and valid, with a byte-masked write port and an asynchronous read port.

Verification
REQ-037: Cold read 0x0000_0040, mem ready at once, response 0x1234_5678 two cycles later -> stall high for 4 cycles, then dout=0x1234_5678 with stall=0.
REQ-038: Repeat the read of 0x40 -> dout=0x1234_5678 one cycle after acceptance, stall never rises, mem_req_valid stays 0.
REQ-039: Store 0x0000_AB00 with we=4'b0010 to 0x41, ready held low for 3 cycles -> mem_req fields stable with mask=0010; then read 0x40 -> 0x1234_AB78.
REQ-040: Store to uncached 0x100, then read 0x100 -> one write request, then a read miss (no allocate on write).
REQ-041: Alias conflict with LINES=64:
  - read 0x0000_0004, then 0x0000_0104;
  - both miss, and the second evicts the first;
  - a re-read of 0x0004 misses.
REQ-042: Reset asserted in RD_WAIT, then mem_resp_valid pulsed -> outputs 0, no fill; the next read of the same address misses.
